// File: rtl/led_pattern_reader.sv
// Read-side sequencer for the LED pattern ROM: prescaled address stepping, ROM enable and
// read-latency handling, registered LED drive, and a clean freeze while the ROM is decoupled.
module led_pattern_reader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned ADDR_LAST = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              decouple,
    output logic              pat_en,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic [DATA_W-1:0] pat_data,
    output logic [DATA_W-1:0] led,
    output logic              led_upd,
    output logic              wrap
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_END   = ADDR_W'(ADDR_LAST);

    typedef enum logic [2:0] {StIdle, StWait, StRead, StCapture, StHold} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   led_q, led_d;
    logic                upd_q, upd_d;
    logic                wrap_q, wrap_d;
    logic                pend_q, pend_d;
    logic                advance;

    assign advance = run || pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (decouple) begin
            state_d = StHold;
        end else begin
            unique case (state_q)
                StIdle:    if (run || step) state_d = StWait;
                StWait: begin
                    if (!advance) begin
                        state_d = StIdle;
                    end else if (presc_q == PRESC_LAST) begin
                        state_d = StRead;
                    end
                end
                StRead:    state_d = StCapture;
                StCapture: state_d = StWait;
                StHold:    state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        pat_en   = (state_q == StRead);
        pat_addr = addr_q;
        led      = led_q;
        led_upd  = upd_q;
        wrap     = wrap_q;
    end

    // Datapath next-state; decouple aborts any in-flight access without touching led/addr.
    always_comb begin
        presc_d = presc_q;
        addr_d  = addr_q;
        led_d   = led_q;
        upd_d   = 1'b0;
        wrap_d  = 1'b0;
        pend_d  = pend_q;
        if (decouple) begin
            presc_d = '0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!run && step) pend_d = 1'b1;
                end
                StWait: begin
                    if (advance) begin
                        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
                    end
                end
                StCapture: begin
                    led_d  = pat_data;
                    upd_d  = 1'b1;
                    pend_d = 1'b0;
                    if (addr_q == ADDR_END) begin
                        addr_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                StHold:  presc_d = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            addr_q  <= '0;
            led_q   <= '0;
            upd_q   <= 1'b0;
            wrap_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            addr_q  <= addr_d;
            led_q   <= led_d;
            upd_q   <= upd_d;
            wrap_q  <= wrap_d;
            pend_q  <= pend_d;
        end
    end

endmodule
